// File: rtl/full_adder.sv
// full_adder: single-bit full adder built from two half_adder cells.
// The first cell adds the operands, the second adds the carry-in to that
// partial sum; at most one of the two cells can produce a carry, so an OR
// merges them into the carry-out.
//   a, b, cin : input bits
//   sum       : a ^ b ^ cin
//   cout      : majority(a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ps;
  logic c0;
  logic c1;

  half_adder u_ha_ab (
    .a     (a),
    .b     (b),
    .sum   (ps),
    .carry (c0)
  );

  half_adder u_ha_cin (
    .a     (ps),
    .b     (cin),
    .sum   (sum),
    .carry (c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// half_adder: single-bit half adder cell from the adders library.
//   a, b   : input bits
//   sum    : a ^ b
//   carry  : a & b
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// A single full_adder plus a carry flop does the arithmetic; operands are
// loaded in parallel on an accepted start and the result is published in
// parallel on the completing edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, only looked at while IDLE
//   a, b, cin  : operands, captured on the accepting edge
//   busy       : high while the add is running
//   done       : one-cycle pulse when sum/cout hold a fresh result
//   sum, cout  : registered result, held until the next completion
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;

  logic               fa_sum;
  logic               fa_cout;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // State and datapath registers.
  // NOTE: the datapath registers are reset too, so an abandoned add leaves
  // no stale operands or partial sum behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves state_d
    // unassigned, which would otherwise infer a latch.
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = (cnt_q == CNT_LAST) ? DONE : RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;  // unused code recovers to IDLE
    endcase
  end

  // Datapath: load on accept, one serial step per RUN cycle.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        // Each new result bit enters at the top; after WIDTH steps the
        // first (LSB) bit has walked down to position 0.
        acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d  = {fa_sum, acc_q[WIDTH-1:1]};
          cout_d = fa_cout;
        end
      end
      default: ;
    endcase
  end

  // Outputs decode registered state only.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder.
// An 8-bit instance covers handshake timing, result hold, ignored starts,
// back-to-back operation and asynchronous reset; a 4-bit instance is swept
// over every operand/carry combination. Expected results come from plain
// integer addition.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       cin4;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;

  int checks   = 0;
  int failures = 0;

  // Last result the 8-bit instance should be holding.
  logic [7:0] prev_sum;
  logic       prev_cout;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete 8-bit add starting from IDLE. Operands are scrambled right
  // after the accepting edge and start is toggled randomly during RUN; the
  // result must be unaffected by either.
  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input string tag);
    logic [8:0] exp;
    exp   = 9'(av) + 9'(bv) + 9'(cv);
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = cv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    cin   = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      check({tag, " busy"}, {busy, done}, 2'b10);
      check({tag, " hold"}, {cout, sum}, {prev_cout, prev_sum});
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " done"}, {busy, done}, 2'b01);
    check({tag, " result"}, {cout, sum}, exp);
    prev_cout = exp[8];
    prev_sum  = exp[7:0];
    @(negedge clk);
    check({tag, " idle"}, {busy, done, cout, sum}, {2'b00, exp});
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int         n_done;
    logic [4:0] exp4;

    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    start4    = 1'b0;
    a4        = '0;
    b4        = '0;
    cin4      = 1'b0;
    prev_sum  = '0;
    prev_cout = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset8", {busy, done, cout, sum}, 11'd0);
    check("reset4", {busy4, done4, cout4, sum4}, 7'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy, done}, 2'b00);

    // Directed adds, including the carry boundaries and result hold.
    run_op8(8'h35, 8'h4A, 1'b0, "t1_35_4a");
    run_op8(8'hFF, 8'h01, 1'b0, "t2_ff_01");
    run_op8(8'hFF, 8'hFF, 1'b1, "t2_ff_ff_c");
    run_op8(8'h0F, 8'h01, 1'b0, "t5_0f_01");
    run_op8(8'hF0, 8'h0F, 1'b0, "t5_f0_0f");
    run_op8(8'h00, 8'h00, 1'b1, "cin_only");

    // Random adds.
    for (int i = 0; i < 16; i++)
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), "rand");

    // start held high: one add every 10 cycles, operands taken at the IDLE
    // edge that accepts them.
    start  = 1'b1;
    a      = 8'h10;
    b      = 8'h20;
    cin    = 1'b0;
    n_done = 0;
    @(posedge clk);
    @(negedge clk);
    a = 8'hAA;
    b = 8'h55;
    for (int n = 0; n < 30; n++) begin
      check("hold_start done", done, (n % 10 == 8) ? 1'b1 : 1'b0);
      if (done) n_done++;
      if (n == 8)  check("hold_start r1", {cout, sum}, 9'h030);
      if (n == 18) check("hold_start r2", {cout, sum}, 9'h0FF);
      if (n == 28) check("hold_start r3", {cout, sum}, 9'h002);
      if (n == 12) begin
        a = 8'h01;
        b = 8'h01;
      end
      if (n == 29) start = 1'b0;
      @(negedge clk);
    end
    check("hold_start count", n_done, 3);
    check("hold_start idle", {busy, done}, 2'b00);
    prev_sum  = 8'h02;
    prev_cout = 1'b0;

    // Reset during the 4th busy cycle.
    start = 1'b1;
    a     = 8'h80;
    b     = 8'h80;
    cin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_reset busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_reset async", {busy, done, cout, sum}, 11'd0);
    prev_sum  = '0;
    prev_cout = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("mid_reset no_done", n_done, 0);
    check("mid_reset idle", {busy, cout, sum}, 10'd0);
    run_op8(8'h01, 8'h02, 1'b0, "after_reset");

    // Exhaustive 4-bit sweep.
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          exp4   = 5'(av) + 5'(bv) + 5'(cv);
          start4 = 1'b1;
          a4     = 4'(av);
          b4     = 4'(bv);
          cin4   = 1'(cv);
          @(posedge clk);
          @(negedge clk);
          start4 = 1'b0;
          a4     = 4'($urandom);
          b4     = 4'($urandom);
          cin4   = 1'($urandom);
          repeat (4) @(negedge clk);
          check("sweep4", {done4, cout4, sum4}, {1'b1, exp4});
          @(negedge clk);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
